ibex_multdiv_issue: RTL and testbench

IBEX_MULTDIV_ISSUE -- requirements
Module: ibex_multdiv_issue

---
 rtl/ibex_pkg.sv | 27 ++
 rtl/ibex_multdiv_issue.sv | 152 +++++++++++++++
 tb/tb_ibex_multdiv_issue.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/ibex_pkg.sv
// Shared Ibex types for the multiply/divide issue path.
// Holds the multdiv operator encoding, the issue FSM state type and the issue watchdog limit.
// No ports; import with ibex_pkg::*.
package ibex_pkg;

   typedef enum logic [1:0] {
      MD_OP_MULL = 2'b00,
      MD_OP_MULH = 2'b01,
      MD_OP_DIV  = 2'b10,
      MD_OP_REM  = 2'b11
   } md_op_e;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      RESP
   } md_issue_fsm_e;

   // Cycles an operation may spend in ISSUE/DRAIN before the watchdog fires.
   localparam logic [5:0] MD_ISSUE_TIMEOUT = 6'd40;

   function automatic logic is_mult_op(input md_op_e op);
      return (op == MD_OP_MULL) || (op == MD_OP_MULH);
   endfunction

endpackage

// File: rtl/ibex_multdiv_issue.sv
// Purpose : accepts one multiply/divide request, holds the enables to ibex_multdiv_slow until it
//           answers, then presents the result with its destination tag.
// Latency : enables rise the cycle after acceptance; rsp_valid_o rises the cycle after md_valid_i.
// Backpressure: req_ready_o is high only in IDLE; the result is held in RESP until rsp_ready_i.
// Ports   : clk_i/rst_i (sync, active-high); req_* request; flush_i kill; mult_en_o/div_en_o,
//           operator_o, signed_mode_o, op_a_o, op_b_o to the unit; md_valid_i/md_result_i from it;
//           rsp_* response; busy_o; timeout_o sticky watchdog flag.
// Config  : IBEX_MULTDIV_ISSUE_TIMEOUT_EN builds the issue watchdog; otherwise timeout_o is 0.
module ibex_multdiv_issue
   import ibex_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  md_op_e      req_op_i,
   input  logic [1:0]  req_signed_mode_i,
   input  logic [31:0] req_op_a_i,
   input  logic [31:0] req_op_b_i,
   input  logic [4:0]  req_tag_i,
   input  logic        flush_i,
   output logic        mult_en_o,
   output logic        div_en_o,
   output md_op_e      operator_o,
   output logic [1:0]  signed_mode_o,
   output logic [31:0] op_a_o,
   output logic [31:0] op_b_o,
   input  logic        md_valid_i,
   input  logic [31:0] md_result_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_result_o,
   output logic [4:0]  rsp_tag_o,
   output logic        busy_o,
   output logic        timeout_o
);

   md_issue_fsm_e state_q, state_d;
   logic          accept;
   logic          capture;
   logic          run_next;
   md_op_e        op_next;

`ifdef IBEX_MULTDIV_ISSUE_TIMEOUT_EN
   logic [5:0]    wdog_q;
   logic          timeout_q;
   logic          timeout_hit;
`endif

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      capture = 1'b0;
`ifdef IBEX_MULTDIV_ISSUE_TIMEOUT_EN
      timeout_hit = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (req_valid_i && !flush_i) begin
               accept  = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (md_valid_i) begin
               capture = !flush_i;
               state_d = flush_i ? IDLE : RESP;
            end else if (flush_i) begin
               // The unit freezes if its enable drops, so keep it running until it answers.
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (md_valid_i) begin
               state_d = IDLE;
            end
         end
         RESP: begin
            if (rsp_ready_i || flush_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
`ifdef IBEX_MULTDIV_ISSUE_TIMEOUT_EN
      // Counter value 39 means this is the 40th cycle in ISSUE/DRAIN with no answer.
      if ((state_q == ISSUE || state_q == DRAIN) && !md_valid_i &&
          (wdog_q == MD_ISSUE_TIMEOUT - 6'd1)) begin
         timeout_hit = 1'b1;
         state_d     = IDLE;
      end
`endif
   end

   // Enables are registered from the next state and the operator that will be held then.
   assign run_next = (state_d == ISSUE) || (state_d == DRAIN);
   assign op_next  = accept ? req_op_i : operator_o;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= IDLE;
         mult_en_o     <= 1'b0;
         div_en_o      <= 1'b0;
         operator_o    <= MD_OP_MULL;
         signed_mode_o <= 2'b00;
         op_a_o        <= 32'd0;
         op_b_o        <= 32'd0;
         rsp_result_o  <= 32'd0;
         rsp_tag_o     <= 5'd0;
      end else begin
         state_q   <= state_d;
         mult_en_o <= run_next && is_mult_op(op_next);
         div_en_o  <= run_next && !is_mult_op(op_next);
         if (accept) begin
            operator_o    <= req_op_i;
            signed_mode_o <= req_signed_mode_i;
            op_a_o        <= req_op_a_i;
            op_b_o        <= req_op_b_i;
            rsp_tag_o     <= req_tag_i;
         end
         if (capture) begin
            rsp_result_o <= md_result_i;
         end
      end
   end

`ifdef IBEX_MULTDIV_ISSUE_TIMEOUT_EN
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wdog_q    <= 6'd0;
         timeout_q <= 1'b0;
      end else begin
         if (accept) begin
            wdog_q <= 6'd0;
         end else if (state_q == ISSUE || state_q == DRAIN) begin
            wdog_q <= wdog_q + 6'd1;
         end
         if (timeout_hit) begin
            timeout_q <= 1'b1;
         end
      end
   end
   assign timeout_o = timeout_q;
`else
   assign timeout_o = 1'b0;
`endif

   assign req_ready_o = (state_q == IDLE);
   assign busy_o      = (state_q != IDLE);
   assign rsp_valid_o = (state_q == RESP);

endmodule

// File: tb/tb_ibex_multdiv_issue.sv
// Bench for ibex_multdiv_issue: directed scenarios plus randomized transactions, each checked
// against a transaction-level expectation (operation result, response presence, timing).
module tb_ibex_multdiv_issue;
   import ibex_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        req_valid_i;
   logic        req_ready_o;
   md_op_e      req_op_i;
   logic [1:0]  req_signed_mode_i;
   logic [31:0] req_op_a_i, req_op_b_i;
   logic [4:0]  req_tag_i;
   logic        flush_i;
   logic        mult_en_o, div_en_o;
   md_op_e      operator_o;
   logic [1:0]  signed_mode_o;
   logic [31:0] op_a_o, op_b_o;
   logic        md_valid_i;
   logic [31:0] md_result_i;
   logic        rsp_valid_o;
   logic        rsp_ready_i;
   logic [31:0] rsp_result_o;
   logic [4:0]  rsp_tag_o;
   logic        busy_o;
   logic        timeout_o;

   int n_tests = 0;
   int n_fail  = 0;

   ibex_multdiv_issue dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
      .req_signed_mode_i(req_signed_mode_i), .req_op_a_i(req_op_a_i), .req_op_b_i(req_op_b_i),
      .req_tag_i(req_tag_i), .flush_i(flush_i),
      .mult_en_o(mult_en_o), .div_en_o(div_en_o), .operator_o(operator_o),
      .signed_mode_o(signed_mode_o), .op_a_o(op_a_o), .op_b_o(op_b_o),
      .md_valid_i(md_valid_i), .md_result_i(md_result_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_result_o(rsp_result_o), .rsp_tag_o(rsp_tag_o),
      .busy_o(busy_o), .timeout_o(timeout_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // What the multdiv unit would answer; the issue block must forward it untouched.
   function automatic logic [31:0] md_ref(input logic [1:0] op, input logic [1:0] sm,
                                          input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, p;
      logic [63:0] pu;
      sa = sm[0] ? longint'($signed(a)) : longint'({32'd0, a});
      sb = sm[1] ? longint'($signed(b)) : longint'({32'd0, b});
      p  = sa * sb;
      pu = p;
      case (op)
         2'd0: return pu[31:0];
         2'd1: return pu[63:32];
         default: begin
            if (b == 32'd0) return (op == 2'd2) ? 32'hFFFF_FFFF : a;
            if (sm == 2'b11) begin
               sa = longint'($signed(a));
               sb = longint'($signed(b));
            end else begin
               sa = longint'({32'd0, a});
               sb = longint'({32'd0, b});
            end
            p  = (op == 2'd2) ? (sa / sb) : (sa % sb);
            pu = p;
            return pu[31:0];
         end
      endcase
   endfunction

   task automatic idle_inputs();
      req_valid_i = 1'b0; flush_i = 1'b0; md_valid_i = 1'b0; rsp_ready_i = 1'b0;
      md_result_i = $urandom;
   endtask

   // One transaction starting at a negedge with the DUT idle.
   // k: cycle of md_valid_i (accept = cycle 0); flush_at: cycle of a flush pulse (<0 none);
   // wait_n: cycles rsp_ready_i stays low in RESP; flush_resp: end RESP with flush_i.
   task automatic run_op(input logic [1:0] op, input logic [1:0] sm, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag, input int k,
                         input int flush_at, input int wait_n, input bit flush_resp);
      logic [31:0] res;
      bit killed;
      bit rsp_seen;
      res    = md_ref(op, sm, a, b);
      killed = (flush_at >= 1) && (flush_at <= k);
      check("idle_req_ready", req_ready_o, 1'b1);
      req_valid_i = 1'b1; req_op_i = md_op_e'(op); req_signed_mode_i = sm;
      req_op_a_i = a; req_op_b_i = b; req_tag_i = tag;
      @(negedge clk_i);
      req_valid_i = 1'b0;
      req_op_a_i = $urandom; req_op_b_i = $urandom; req_tag_i = 5'($urandom);
      rsp_seen = 1'b0;
      for (int c = 1; c <= k; c++) begin
         check("mult_en", mult_en_o, op < 2'd2);
         check("div_en", div_en_o, op >= 2'd2);
         check("busy", busy_o, 1'b1);
         check("req_ready_busy", req_ready_o, 1'b0);
         check("operator_hold", operator_o, op);
         check("sm_hold", signed_mode_o, sm);
         check("op_a_hold", op_a_o, a);
         check("op_b_hold", op_b_o, b);
         rsp_seen |= rsp_valid_o;
         flush_i     = (c == flush_at);
         md_valid_i  = (c == k);
         md_result_i = (c == k) ? res : $urandom;
         @(negedge clk_i);
      end
      flush_i = 1'b0; md_valid_i = 1'b0;
      check("rsp_early", rsp_seen, 1'b0);
      if (killed) begin
         check("kill_rsp_valid", rsp_valid_o, 1'b0);
         check("kill_req_ready", req_ready_o, 1'b1);
         check("kill_en", {mult_en_o, div_en_o}, 2'b00);
      end else begin
         for (int w = 0; w <= wait_n; w++) begin
            check("rsp_valid", rsp_valid_o, 1'b1);
            check("rsp_result", rsp_result_o, res);
            check("rsp_tag", rsp_tag_o, tag);
            check("rsp_req_ready", req_ready_o, 1'b0);
            check("rsp_en", {mult_en_o, div_en_o}, 2'b00);
            md_valid_i  = 1'($urandom_range(0, 1));
            md_result_i = $urandom;
            if (w == wait_n) begin
               flush_i     = flush_resp;
               rsp_ready_i = flush_resp ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            @(negedge clk_i);
         end
         idle_inputs();
         check("post_rsp_ready", req_ready_o, 1'b1);
         check("post_rsp_valid", rsp_valid_o, 1'b0);
      end
      check("timeout_clear", timeout_o, 1'b0);
   endtask

   initial begin
      logic [1:0] op;
      int k, fa;
      rst_i = 1'b1;
      idle_inputs();
      req_op_i = MD_OP_MULL; req_signed_mode_i = 2'b00;
      req_op_a_i = 32'd0; req_op_b_i = 32'd0; req_tag_i = 5'd0;
      @(negedge clk_i);
      @(negedge clk_i);
      check("rst_req_ready", req_ready_o, 1'b1);
      check("rst_outs", {mult_en_o, div_en_o, rsp_valid_o, busy_o, timeout_o}, 5'd0);
      check("rst_data", {operator_o, signed_mode_o, op_a_o, op_b_o}, 68'd0);
      check("rst_rsp", {rsp_result_o, rsp_tag_o}, 37'd0);
      rst_i = 1'b0;
      @(negedge clk_i);

      // md_valid_i while idle is ignored.
      md_valid_i = 1'b1; md_result_i = 32'hDEAD_BEEF;
      @(negedge clk_i);
      md_valid_i = 1'b0;
      check("idle_md_ignored", {rsp_valid_o, busy_o}, 2'b00);

      // A flushed request in IDLE is not accepted.
      req_valid_i = 1'b1; flush_i = 1'b1;
      @(negedge clk_i);
      idle_inputs();
      check("flush_req_busy", busy_o, 1'b0);
      check("flush_req_ready", req_ready_o, 1'b1);

      run_op(2'd0, 2'b00, 32'd7, 32'd6, 5'd3, 33, -1, 0, 1'b0);     // MULL 7*6
      run_op(2'd2, 2'b11, 32'd100, 32'd7, 5'd9, 20, -1, 5, 1'b0);   // DIV, held 5 cycles
      run_op(2'd3, 2'b11, 32'd100, 32'd7, 5'd4, 37, 10, 0, 1'b0);   // REM flushed at 10
      run_op(2'd1, 2'b01, 32'hFFFF_FFF0, 32'd3, 5'd1, 12, 12, 0, 1'b0); // flush with md_valid
      run_op(2'd2, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 5'd31, 8, -1, 2, 1'b1); // flush in RESP

      // Reset during ISSUE: enables drop next cycle and a late answer is ignored.
      req_valid_i = 1'b1; req_op_i = MD_OP_DIV; req_op_a_i = 32'd50; req_op_b_i = 32'd5;
      req_tag_i = 5'd7;
      @(negedge clk_i);
      req_valid_i = 1'b0;
      for (int c = 1; c < 5; c++) @(negedge clk_i);
      check("pre_rst_div_en", div_en_o, 1'b1);
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      check("mid_rst_en", {mult_en_o, div_en_o}, 2'b00);
      check("mid_rst_busy", busy_o, 1'b0);
      check("mid_rst_ready", req_ready_o, 1'b1);
      md_valid_i = 1'b1; md_result_i = 32'd10;
      @(negedge clk_i);
      md_valid_i = 1'b0;
      @(negedge clk_i);
      check("late_md_ignored", {rsp_valid_o, busy_o}, 2'b00);

      for (int t = 0; t < 60; t++) begin
         op = 2'($urandom_range(0, 3));
         k  = $urandom_range(1, 38);
         fa = ($urandom_range(0, 9) < 3) ? $urandom_range(1, k) : -1;
         if (($urandom_range(0, 9) < 2) && (op >= 2'd2))
            run_op(op, 2'($urandom), $urandom, 32'd0, 5'($urandom), k, fa,
                   $urandom_range(0, 4), 1'($urandom_range(0, 4) == 0));
         else
            run_op(op, 2'($urandom), $urandom, $urandom, 5'($urandom), k, fa,
                   $urandom_range(0, 4), 1'($urandom_range(0, 4) == 0));
      end

`ifdef IBEX_MULTDIV_ISSUE_TIMEOUT_EN
      // Watchdog: 40 cycles in ISSUE without an answer.
      req_valid_i = 1'b1; req_op_i = MD_OP_MULH;
      @(negedge clk_i);
      req_valid_i = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         check("wdog_en", mult_en_o, 1'b1);
         check("wdog_not_yet", timeout_o, 1'b0);
         @(negedge clk_i);
      end
      check("wdog_timeout", timeout_o, 1'b1);
      check("wdog_en_drop", {mult_en_o, div_en_o, busy_o}, 3'b000);
      for (int c = 0; c < 5; c++) @(negedge clk_i);
      check("wdog_sticky", timeout_o, 1'b1);
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      check("wdog_rst_clear", timeout_o, 1'b0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
